// File: rtl/ufi_atb_read_dma_if.sv
// Signal bundle between the ATB read DMA and its neighbours: command input,
// the ATB request port of the UFI hub, the byte stream, and status.
//
// Valid/ready: a beat moves on a rising clock edge where valid and ready are
// both high; a source keeps valid and its payload steady until that edge.
interface ufi_atb_read_dma_if #(
  parameter int pUfiBusWidth = 8,
  parameter int pBusAdrsBit  = 32,
  parameter int pLenBit      = 16
);
  logic [pBusAdrsBit-1:0]  iCmdAdrs;
  logic [pLenBit-1:0]      iCmdLen;
  logic                    iCmdVd;
  logic                    oCmdRdy;

  logic [pBusAdrsBit-1:0]  oMUfiAdrsAtb;
  logic                    oMUfiWEdAtb;
  logic                    oMUfiREdAtb;
  logic                    oMUfiVdAtb;
  logic                    iMUfiRdyAtb;
  logic                    iMUfiRdy;
  logic [pUfiBusWidth-1:0] iMUfiRd;
  logic                    iMUfiEddAtb;

  logic [pUfiBusWidth-1:0] oStrmData;
  logic                    oStrmVd;
  logic                    iStrmRdy;

  logic                    oBusy;
  logic                    oDone;
  logic [2:0]              oDbgState;

  modport master (
    input  iCmdAdrs, iCmdLen, iCmdVd,
    input  iMUfiRdyAtb, iMUfiRdy, iMUfiRd, iMUfiEddAtb,
    input  iStrmRdy,
    output oCmdRdy,
    output oMUfiAdrsAtb, oMUfiWEdAtb, oMUfiREdAtb, oMUfiVdAtb,
    output oStrmData, oStrmVd,
    output oBusy, oDone, oDbgState
  );

  modport slave (
    output iCmdAdrs, iCmdLen, iCmdVd,
    output iMUfiRdyAtb, iMUfiRdy, iMUfiRd, iMUfiEddAtb,
    output iStrmRdy,
    input  oCmdRdy,
    input  oMUfiAdrsAtb, oMUfiWEdAtb, oMUfiREdAtb, oMUfiVdAtb,
    input  oStrmData, oStrmVd,
    input  oBusy, oDone, oDbgState
  );
endinterface

// File: rtl/ufi_atb_read_dma.sv
// Read-only burst DMA on the hub's ATB port: one read strobe per byte,
// credit-limited by a return FIFO that feeds an in-order byte stream.
module ufi_atb_read_dma #(
  parameter int pUfiBusWidth = 8,
  parameter int pBusAdrsBit  = 32,
  parameter int pLenBit      = 16,
  parameter int pFifoDepth   = 16
) (
  input logic iUfiClk,
  input logic iUfiRst,
  ufi_atb_read_dma_if.master bus
);
  localparam int cPtrBit = $clog2(pFifoDepth);
  localparam int cCntBit = cPtrBit + 1;
  localparam logic [cCntBit:0] cDepth = (cCntBit+1)'(pFifoDepth);

  typedef enum logic [2:0] {sIdle, sReq, sIssue, sDrain, sDone} state_t;

  state_t                  state, stateNxt;
  logic                    cmdArmed;
  logic [pBusAdrsBit-1:0]  issuePtr;
  logic [pLenBit-1:0]      issueRem, recvRem;
  logic [cCntBit-1:0]      inflight, fifoCount;
  logic [cPtrBit-1:0]      wrPtr, rdPtr;
  logic [pUfiBusWidth-1:0] fifoMem [pFifoDepth];
  logic                    strbPend;

  logic             cmdRdy, cmdAcc, active, creditOk;
  logic             issue, drop, ret, pop;
  logic             vdAtb, doneP;
  logic [cCntBit:0] reserved;

  assign active   = (state == sReq) || (state == sIssue) || (state == sDrain);
  assign cmdAcc   = bus.iCmdVd && cmdRdy;
  assign reserved = {1'b0, fifoCount} + {1'b0, inflight};
  assign creditOk = reserved < cDepth;
  assign issue    = (state == sIssue) && bus.iMUfiRdyAtb && bus.iMUfiRdy &&
                    (issueRem != '0) && creditOk;
  // The hub's grant is registered: a strobe is only known to have been
  // forwarded when the grant is still high one cycle later.
  assign drop     = strbPend && !bus.iMUfiRdyAtb;
  assign ret      = active && bus.iMUfiEddAtb;
  assign pop      = bus.oStrmVd && bus.iStrmRdy;

  always_ff @(posedge iUfiClk or posedge iUfiRst) begin
    if (iUfiRst) begin
      state    <= sIdle;
      cmdArmed <= 1'b0;
      strbPend <= 1'b0;
      issuePtr <= '0;
      issueRem <= '0;
      recvRem  <= '0;
      inflight <= '0;
    end else begin
      state    <= stateNxt;
      cmdArmed <= 1'b1;
      strbPend <= issue;
      if (state == sIdle && cmdAcc && bus.iCmdLen != '0) begin
        issuePtr <= bus.iCmdAdrs;
        issueRem <= bus.iCmdLen;
        recvRem  <= bus.iCmdLen;
        inflight <= '0;
      end else begin
        if (issue) begin
          issuePtr <= issuePtr + pBusAdrsBit'(1);
          issueRem <= issueRem - pLenBit'(1);
        end else if (drop) begin
          issuePtr <= issuePtr - pBusAdrsBit'(1);
          issueRem <= issueRem + pLenBit'(1);
        end
        if (ret) recvRem <= recvRem - pLenBit'(1);
        inflight <= inflight + cCntBit'(issue) - cCntBit'(ret) - cCntBit'(drop);
      end
    end
  end

  always_ff @(posedge iUfiClk or posedge iUfiRst) begin
    if (iUfiRst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (ret) wrPtr <= wrPtr + cPtrBit'(1);
      if (pop) rdPtr <= rdPtr + cPtrBit'(1);
      fifoCount <= fifoCount + cCntBit'(ret) - cCntBit'(pop);
    end
  end

  always_ff @(posedge iUfiClk) begin
    if (ret) fifoMem[wrPtr] <= bus.iMUfiRd;
  end

  always_comb begin
    stateNxt = state;
    cmdRdy   = 1'b0;
    vdAtb    = 1'b0;
    doneP    = 1'b0;
    case (state)
      sIdle: begin
        cmdRdy = cmdArmed;
        if (cmdAcc) stateNxt = (bus.iCmdLen == '0) ? sDone : sReq;
      end
      sReq: begin
        vdAtb = 1'b1;
        if (bus.iMUfiRdyAtb) stateNxt = sIssue;
      end
      sIssue: begin
        vdAtb = 1'b1;
        if (issue && issueRem == pLenBit'(1)) stateNxt = sDrain;
      end
      sDrain: begin
        vdAtb = (recvRem != '0);
        if (drop) stateNxt = sIssue;
        else if (recvRem == '0 && fifoCount == '0) stateNxt = sDone;
      end
      sDone: begin
        doneP    = 1'b1;
        stateNxt = sIdle;
      end
      default: stateNxt = sIdle;
    endcase
  end

  assign bus.oCmdRdy      = cmdRdy;
  assign bus.oMUfiVdAtb   = vdAtb;
  assign bus.oMUfiREdAtb  = issue;
  assign bus.oMUfiAdrsAtb = issue ? issuePtr : '0;
  assign bus.oMUfiWEdAtb  = 1'b0;
  assign bus.oStrmVd      = (fifoCount != '0);
  assign bus.oStrmData    = (fifoCount != '0) ? fifoMem[rdPtr] : '0;
  assign bus.oBusy        = active;
  assign bus.oDone        = doneP;
  assign bus.oDbgState    = state;
endmodule

// File: tb/tb_ufi_atb_read_dma.sv
// Bench for ufi_atb_read_dma: a hub/RAM responder plus a byte-level model of
// the burst (expected addresses, expected bytes, reservation counts).
module tb_ufi_atb_read_dma;
  localparam int W     = 8;
  localparam int AB    = 32;
  localparam int LB    = 16;
  localparam int DEPTH = 16;

  logic iUfiClk = 1'b0;
  logic iUfiRst = 1'b1;
  always #5 iUfiClk = ~iUfiClk;

  ufi_atb_read_dma_if #(.pUfiBusWidth(W), .pBusAdrsBit(AB), .pLenBit(LB)) bus ();

  ufi_atb_read_dma #(
    .pUfiBusWidth(W), .pBusAdrsBit(AB), .pLenBit(LB), .pFifoDepth(DEPTH)
  ) dut (
    .iUfiClk(iUfiClk),
    .iUfiRst(iUfiRst),
    .bus(bus)
  );

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [W-1:0]  exp_q[$];
  logic [AB-1:0] red_log[$];
  int            red_cyc[$];
  logic [W-1:0]  strm_log[$];

  logic [AB-1:0] next_adr;
  int            held, fifo_occ, done_cnt, cmd_cyc, done_cyc;
  bit            vd_seen, cmd_taken;
  bit            drop_en, drop_done;
  logic [AB-1:0] drop_adr;
  bit            rv_pipe[3];
  logic [W-1:0]  rd_pipe[3];
  logic          nxt_rdyatb;

  logic [AB-1:0] t3_adrs[9] = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h204,
                                32'h205, 32'h205, 32'h206, 32'h207};
  logic [AB-1:0] t6_adrs[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
  logic [W-1:0]  t6_data[3] = '{8'hA4, 8'hA5, 8'hA5};

  // RAM content: every address returns a byte derived from the address.
  function automatic logic [W-1:0] data_of(input logic [AB-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample and check at negedge, then drive hub inputs after posedge.
  task automatic step();
    bit dropping;
    bit pop_now;
    bit rv_new;
    logic [W-1:0] rd_new;
    dropping = 1'b0;
    rv_new   = 1'b0;
    rd_new   = '0;
    @(negedge iUfiClk);
    cyc++;
    if (iUfiRst) begin
      exp_q.delete();
      held       = 0;
      fifo_occ   = 0;
      nxt_rdyatb = 1'b0;
    end else begin
      if (bus.iCmdVd && bus.oCmdRdy) begin
        cmd_taken = 1'b1;
        cmd_cyc   = cyc;
        next_adr  = bus.iCmdAdrs;
        for (int i = 0; i < int'(bus.iCmdLen); i++)
          exp_q.push_back(data_of(bus.iCmdAdrs + AB'(i)));
      end
      if (bus.oMUfiVdAtb) begin
        vd_seen = 1'b1;
        check("wed_low", 64'(bus.oMUfiWEdAtb), 64'(0));
      end
      if (bus.oMUfiREdAtb) begin
        check("red_adr", 64'(bus.oMUfiAdrsAtb), 64'(next_adr));
        check("red_gate", 64'({bus.oMUfiVdAtb, bus.iMUfiRdy, bus.iMUfiRdyAtb}), 64'(3'b111));
        red_log.push_back(bus.oMUfiAdrsAtb);
        red_cyc.push_back(cyc);
        if (drop_en && !drop_done && bus.oMUfiAdrsAtb == drop_adr) begin
          dropping  = 1'b1;
          drop_done = 1'b1;
        end else begin
          next_adr = next_adr + AB'(1);
          held++;
          rv_new = 1'b1;
          rd_new = data_of(bus.oMUfiAdrsAtb);
        end
      end
      pop_now = bus.oStrmVd && bus.iStrmRdy;
      if (bus.iMUfiEddAtb && bus.oBusy) fifo_occ++;
      if (pop_now) begin
        fifo_occ--;
        held--;
        strm_log.push_back(bus.oStrmData);
        if (exp_q.size() == 0) check("strm_extra", 64'(bus.oStrmData), 64'hDEAD);
        else check("strm_data", 64'(bus.oStrmData), 64'(exp_q.pop_front()));
      end
      if (bus.oBusy) begin
        check("credit", 64'(held > DEPTH), 64'(0));
        check("fifo_ovf", 64'(fifo_occ > DEPTH), 64'(0));
      end
      if (bus.oDone) begin
        done_cnt++;
        done_cyc = cyc;
      end
      nxt_rdyatb = bus.oMUfiVdAtb && !dropping;
    end
    rv_pipe[0] = rv_pipe[1];
    rd_pipe[0] = rd_pipe[1];
    rv_pipe[1] = rv_pipe[2];
    rd_pipe[1] = rd_pipe[2];
    rv_pipe[2] = rv_new;
    rd_pipe[2] = rd_new;
    @(posedge iUfiClk);
    #1;
    bus.iMUfiRdyAtb = nxt_rdyatb;
    bus.iMUfiEddAtb = rv_pipe[0];
    bus.iMUfiRd     = rv_pipe[0] ? rd_pipe[0] : '0;
  endtask

  task automatic clear_logs();
    red_log.delete();
    red_cyc.delete();
    strm_log.delete();
    done_cnt = 0;
    vd_seen  = 1'b0;
  endtask

  task automatic send_cmd(input logic [AB-1:0] a, input logic [LB-1:0] l);
    bus.iCmdAdrs = a;
    bus.iCmdLen  = l;
    bus.iCmdVd   = 1'b1;
    cmd_taken    = 1'b0;
    for (int i = 0; i < 20 && !cmd_taken; i++) step();
    bus.iCmdVd = 1'b0;
    check("cmd_accept", 64'(cmd_taken), 64'(1));
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) step();
    step();
    step();
    check("done_once", 64'(done_cnt), 64'(1));
    check("busy_after", 64'(bus.oBusy), 64'(0));
    check("all_bytes_out", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_red_seq(input string name, input logic [AB-1:0] base, input int n);
    check(name, 64'(red_log.size()), 64'(n));
    for (int i = 0; i < n && i < red_log.size(); i++)
      check(name, 64'(red_log[i]), 64'(base + AB'(i)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.iCmdAdrs    = '0;
    bus.iCmdLen     = '0;
    bus.iCmdVd      = 1'b0;
    bus.iMUfiRdyAtb = 1'b0;
    bus.iMUfiRdy    = 1'b1;
    bus.iMUfiRd     = '0;
    bus.iMUfiEddAtb = 1'b0;
    bus.iStrmRdy    = 1'b1;
    drop_en = 1'b0;
    drop_done = 1'b0;
    drop_adr = '0;
    for (int i = 0; i < 3; i++) begin
      rv_pipe[i] = 1'b0;
      rd_pipe[i] = '0;
    end

    // Reset state and the first-edge rise of the command ready.
    repeat (3) step();
    check("rst_outs", 64'({bus.oCmdRdy, bus.oMUfiVdAtb, bus.oMUfiREdAtb, bus.oMUfiWEdAtb,
                           bus.oStrmVd, bus.oBusy, bus.oDone}), 64'(0));
    check("rst_adrs", 64'(bus.oMUfiAdrsAtb), 64'(0));
    check("rst_state", 64'(bus.oDbgState), 64'(0));
    iUfiRst = 1'b0;
    #2;
    check("cmdrdy_before_edge", 64'(bus.oCmdRdy), 64'(0));
    step();
    check("cmdrdy_after_edge", 64'(bus.oCmdRdy), 64'(1));

    // 1: four-byte burst, back-to-back strobes, bytes in order.
    clear_logs();
    send_cmd(32'h100, 16'd4);
    wait_done(100);
    check_red_seq("t1_adrs", 32'h100, 4);
    check("t1_first_lat", 64'(red_cyc.size() > 0 ? red_cyc[0] - cmd_cyc : -1), 64'(3));
    check("t1_consec", 64'(red_cyc.size() == 4 ? red_cyc[3] - red_cyc[0] : -1), 64'(3));
    check("t1_nbytes", 64'(strm_log.size()), 64'(4));
    check("t1_b0", 64'(strm_log.size() > 0 ? strm_log[0] : 8'h00), 64'(8'hA4));
    check("t1_b3", 64'(strm_log.size() > 3 ? strm_log[3] : 8'h00), 64'(8'hA7));

    // 2: stalled stream, credit caps reservations at the FIFO depth.
    clear_logs();
    bus.iStrmRdy = 1'b0;
    send_cmd(32'h1000, 16'd40);
    repeat (40) step();
    check("t2_credit_stop", 64'(red_log.size()), 64'(DEPTH));
    bus.iStrmRdy = 1'b1;
    wait_done(600);
    check_red_seq("t2_adrs", 32'h1000, 40);
    check("t2_nbytes", 64'(strm_log.size()), 64'(40));

    // 3: hub drops the strobe for 0x205; it is reissued, stream stays contiguous.
    clear_logs();
    drop_en   = 1'b1;
    drop_done = 1'b0;
    drop_adr  = 32'h205;
    send_cmd(32'h200, 16'd8);
    wait_done(200);
    drop_en = 1'b0;
    check("t3_nred", 64'(red_log.size()), 64'(9));
    for (int i = 0; i < 9 && i < red_log.size(); i++)
      check("t3_adrs", 64'(red_log[i]), 64'(t3_adrs[i]));
    check("t3_regap", 64'(red_cyc.size() > 6 ? red_cyc[6] - red_cyc[5] : -1), 64'(2));
    check("t3_nbytes", 64'(strm_log.size()), 64'(8));

    // 4: zero-length command completes without touching the bus.
    clear_logs();
    send_cmd(32'h400, 16'd0);
    step();
    check("t4_done_next", 64'(done_cyc - cmd_cyc), 64'(1));
    repeat (3) step();
    check("t4_done_cnt", 64'(done_cnt), 64'(1));
    check("t4_no_vd", 64'(vd_seen), 64'(0));

    // 5: RAM not ready for five cycles mid-burst.
    clear_logs();
    send_cmd(32'h300, 16'd12);
    for (int i = 0; i < 50 && red_log.size() < 4; i++) step();
    bus.iMUfiRdy = 1'b0;
    n0 = red_log.size();
    repeat (5) step();
    check("t5_stall_no_red", 64'(red_log.size()), 64'(n0));
    bus.iMUfiRdy = 1'b1;
    wait_done(200);
    check_red_seq("t5_adrs", 32'h300, 12);

    // 6: asynchronous reset mid-burst, then a burst across the address wrap.
    clear_logs();
    send_cmd(32'h500, 16'd20);
    for (int i = 0; i < 50 && red_log.size() < 6; i++) step();
    #2;
    iUfiRst = 1'b1;
    #1;
    check("t6_rst_outs", 64'({bus.oCmdRdy, bus.oMUfiVdAtb, bus.oMUfiREdAtb, bus.oStrmVd,
                              bus.oBusy, bus.oDone}), 64'(0));
    check("t6_rst_adrs", 64'(bus.oMUfiAdrsAtb), 64'(0));
    check("t6_rst_data", 64'(bus.oStrmData), 64'(0));
    repeat (5) step();
    iUfiRst = 1'b0;
    repeat (2) step();
    check("t6_idle_after", 64'({bus.oCmdRdy, bus.oStrmVd, bus.oBusy}), 64'(3'b100));
    clear_logs();
    send_cmd(32'hFFFF_FFFE, 16'd3);
    wait_done(100);
    check("t6_nred", 64'(red_log.size()), 64'(3));
    for (int i = 0; i < 3 && i < red_log.size(); i++)
      check("t6_adrs", 64'(red_log[i]), 64'(t6_adrs[i]));
    check("t6_nbytes", 64'(strm_log.size()), 64'(3));
    for (int i = 0; i < 3 && i < strm_log.size(); i++)
      check("t6_data", 64'(strm_log[i]), 64'(t6_data[i]));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/ufi_atb_read_dma.md
Name: ufi_atb_read_dma

Overview:
- Read-only DMA master that drives the ATB request port of the UFI bus hub.
- Takes a burst command (start address, byte count), holds the ATB valid, and issues one read strobe per byte while the hub grants ATB.
- Collects the returned bytes (routed to ATB by ID) in an internal FIFO and presents them in order on a valid/ready byte stream to the asset pipeline.

Parameters:
- pUfiBusWidth, 8, data width of the UFI bus and of the output stream.
- pBusAdrsBit, 32, address width.
- pLenBit, 16, width of the command byte count.
- pFifoDepth, 16, return FIFO depth in entries; must be a power of two, at least 4.

Ports:
- iUfiClk, in, 1, clock.
- iUfiRst, in, 1, reset, asynchronous, active-high.
- iCmdAdrs, in, pBusAdrsBit, burst start address.
- iCmdLen, in, pLenBit, burst byte count.
- iCmdVd, in, 1, command valid.
- oCmdRdy, out, 1, command accept; a command transfers when iCmdVd and oCmdRdy are both high.
- oMUfiAdrsAtb, out, pBusAdrsBit, read address to the hub.
- oMUfiWEdAtb, out, 1, write strobe; tied to 0.
- oMUfiREdAtb, out, 1, read strobe, one byte per cycle.
- oMUfiVdAtb, out, 1, ATB transfer-period valid.
- iMUfiRdyAtb, in, 1, hub ATB grant; registered, so it reflects the previous cycle's forwarding.
- iMUfiRdy, in, 1, RAM ready, registered by the hub.
- iMUfiRd, in, pUfiBusWidth, read data.
- iMUfiEddAtb, in, 1, read data valid for ATB.
- oStrmData, out, pUfiBusWidth, stream data.
- oStrmVd, out, 1, stream valid.
- iStrmRdy, in, 1, stream ready.
- oBusy, out, 1, high from command accept until done.
- oDone, out, 1, one-cycle pulse at burst completion.

Behaviour:
Reset
- All outputs 0 asynchronously; state IDLE; FIFO empty; counters 0.
- oCmdRdy rises on the first clock edge after reset is released.

States: IDLE, REQ, ISSUE, DRAIN, DONE.
- IDLE: oCmdRdy=1.
  - Accepted command with len=0 -> DONE.
  - Accepted command with len>0 -> latch the address into the issue pointer and len into issue-remaining and receive-remaining -> REQ.
- REQ: oMUfiVdAtb=1, oMUfiREdAtb=0. Go to ISSUE on the first cycle iMUfiRdyAtb=1.
- ISSUE: oMUfiVdAtb=1.
  - Assert oMUfiREdAtb with oMUfiAdrsAtb = issue pointer when all of the following hold: iMUfiRdyAtb=1, iMUfiRdy=1, issue-remaining>0, and fifo_count + inflight < pFifoDepth.
  - Each issued read increments the pointer, decrements issue-remaining, and increments inflight.
  - When issue-remaining reaches 0 -> DRAIN.
- DRAIN: oMUfiVdAtb stays 1 until receive-remaining=0, then drops to 0.
  - When receive-remaining=0 and the FIFO is empty -> DONE.
- DONE: oDone=1 for one cycle; oBusy=0 -> IDLE.
- oBusy=1 in REQ, ISSUE and DRAIN.

Drop recovery (preemption by MCS or SPI)
- A strobe issued in cycle t was forwarded only if iMUfiRdyAtb=1 in cycle t+1.
- If it is 0, that request is lost: rewind the pointer by 1, restore issue-remaining by 1 (returning from DRAIN to ISSUE if needed), and decrement inflight.
- No strobe is issued in that cycle, because the issue condition requires iMUfiRdyAtb=1.
- At most one strobe is ever unconfirmed.
- If iMUfiRdyAtb stays 0, keep oMUfiVdAtb high and wait.

Return path
- iMUfiEddAtb=1 writes iMUfiRd into the FIFO, decrements inflight and decrements receive-remaining.
- Issue in the same cycle as a return: inflight is unchanged.
- Return while in IDLE or DONE: ignored.
- FIFO overflow is impossible by credit; a write while full is a design error and is flagged by a bench assertion.
- The stream is first-word-fall-through: oStrmVd = FIFO non-empty, oStrmData = head entry.
- Pop on oStrmVd & iStrmRdy. Simultaneous push and pop keeps the count.
- fifo_count and inflight are each pLenBit-independent and sized log2(pFifoDepth)+1.

Arithmetic and ordering
- The address increments modulo 2^pBusAdrsBit (wraps from all-ones to 0).
- Bytes are delivered in address order; the RAM returns reads in order.

Test Plan:
1. cmd adrs=0x100 len=4; RdyAtb=1 one cycle after Vd; RAM returns Edd 3 cycles after each REd -> REd at 0x100..0x103 on consecutive cycles; stream outputs bytes d0..d3 in order; oDone pulses once; oBusy low afterwards.
2. len=40, iStrmRdy=0, pFifoDepth=16 -> REd stops after 16 reservations, fifo_count+inflight never exceeds 16; releasing iStrmRdy completes all 40 bytes with no overflow assertion.
3. len=8 at 0x200; force iMUfiRdyAtb=0 in the cycle after the REd of 0x205 -> 0x205 is re-issued; exactly 8 bytes are streamed, 0x200..0x207, contiguous.
4. cmd len=0 -> accepted; oDone the next cycle; oMUfiVdAtb never asserted.
5. iMUfiRdy low for 5 cycles mid-burst -> no REd in those cycles; issue resumes at the next address afterwards.
6. iUfiRst asserted mid-burst, between clock edges -> all outputs 0 immediately; late Edd ignored; a new command at 0xFFFFFFFE len=3 issues 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
